// File: rtl/dsp_arbiter_if.sv
// Bus between the DSP arbiter, its two requesters and the shared DSP vector unit.
interface dsp_arbiter_if #(
  parameter int NUM_LANES = 8,
  parameter int VEC_W     = 32
);
  logic                            r0_req, r1_req;
  logic [1:0]                      r0_op, r1_op;
  logic [NUM_LANES-1:0][VEC_W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic                            r0_gnt, r1_gnt;
  logic                            r0_rsp_valid, r1_rsp_valid;
  logic                            r0_rsp_ready, r1_rsp_ready;
  logic [NUM_LANES-1:0][VEC_W-1:0] rsp_data;
  logic                            rsp_err;
  logic                            dsp_start;
  logic [1:0]                      dsp_op;
  logic [NUM_LANES-1:0][VEC_W-1:0] dsp_a, dsp_b, dsp_result;
  logic                            dsp_done, dsp_rst;
  logic                            busy, last_grant;

  // arbiter side
  modport slave (
    input  r0_req, r0_op, r0_a, r0_b, r0_rsp_ready,
           r1_req, r1_op, r1_a, r1_b, r1_rsp_ready,
           dsp_result, dsp_done,
    output r0_gnt, r0_rsp_valid, r1_gnt, r1_rsp_valid,
           rsp_data, rsp_err, dsp_start, dsp_op, dsp_a, dsp_b,
           dsp_rst, busy, last_grant
  );

  // requester / DSP side
  modport master (
    output r0_req, r0_op, r0_a, r0_b, r0_rsp_ready,
           r1_req, r1_op, r1_a, r1_b, r1_rsp_ready,
           dsp_result, dsp_done,
    input  r0_gnt, r0_rsp_valid, r1_gnt, r1_rsp_valid,
           rsp_data, rsp_err, dsp_start, dsp_op, dsp_a, dsp_b,
           dsp_rst, busy, last_grant
  );
endinterface

// File: rtl/dsp_arbiter.sv
// Two-requester arbiter in front of one DSP vector unit: round-robin grant,
// operand capture, start pulse, done-edge completion, watchdog flush.

// One vector lane: operand registers toward the DSP and the response word.
module dsp_arbiter_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             sel,
  input  logic             rsp_en,
  input  logic             rsp_clr,
  input  logic [VEC_W-1:0] r0_a,
  input  logic [VEC_W-1:0] r0_b,
  input  logic [VEC_W-1:0] r1_a,
  input  logic [VEC_W-1:0] r1_b,
  input  logic [VEC_W-1:0] result,
  output logic [VEC_W-1:0] dsp_a,
  output logic [VEC_W-1:0] dsp_b,
  output logic [VEC_W-1:0] rsp_data
);
  // operands held from grant until the next grant; response loaded on completion/abort
  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_a    <= '0;
      dsp_b    <= '0;
      rsp_data <= '0;
    end else begin
      if (cap_en) begin
        dsp_a <= sel ? r1_a : r0_a;
        dsp_b <= sel ? r1_b : r0_b;
      end
      if (rsp_en) rsp_data <= rsp_clr ? '0 : result;
    end
  end
endmodule

module dsp_arbiter #(
  parameter int TIMEOUT   = 256,
  parameter int FLUSH_CYC = 2,
  parameter int NUM_LANES = 8,
  parameter int VEC_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  dsp_arbiter_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, RESP} state_t;

  state_t                          state, state_nxt;
  logic                            owner, rr_ptr, last_q, rsp_err_q, done_prev;
  logic [1:0]                      op_q;
  logic [TW-1:0]                   tcnt;
  logic [FW-1:0]                   fcnt;
  logic                            win, accept, cmpl, rsp_en, rsp_clr;
  logic [NUM_LANES-1:0][VEC_W-1:0] a_q, b_q, d_q;

  // winner: a lone requester, else whoever the round-robin pointer names
  assign win    = (bus.r0_req & bus.r1_req) ? rr_ptr : bus.r1_req;
  assign accept = (state == IDLE) & (bus.r0_req | bus.r1_req);
  // done is a level; only its rising edge counts as completion
  assign cmpl   = bus.dsp_done & ~done_prev;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and response-load strobes
  always_comb begin
    state_nxt = state;
    rsp_en    = 1'b0;
    rsp_clr   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cmpl) begin
          rsp_en    = 1'b1;
          state_nxt = RESP;
        end else if (tcnt == TW'(TIMEOUT-1)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt == FW'(FLUSH_CYC-1)) begin
          rsp_en    = 1'b1;
          rsp_clr   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:  if (owner ? bus.r1_rsp_ready : bus.r0_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ownership, pointer, op capture, watchdog and flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      last_q    <= 1'b0;
      op_q      <= '0;
      tcnt      <= '0;
      fcnt      <= '0;
      done_prev <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      // tracked every cycle so a done still high from a previous op never looks like an edge
      done_prev <= bus.dsp_done;
      if (accept) begin
        owner  <= win;
        last_q <= win;
        rr_ptr <= ~win;
        op_q   <= win ? bus.r1_op : bus.r0_op;
      end
      if (state == ISSUE)     tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (state == WAIT)       fcnt <= '0;
      else if (state == FLUSH) fcnt <= fcnt + 1'b1;
      if (rsp_en) rsp_err_q <= rsp_clr;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dsp_arbiter_lane #(.VEC_W(VEC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (accept),
      .sel      (win),
      .rsp_en   (rsp_en),
      .rsp_clr  (rsp_clr),
      .r0_a     (bus.r0_a[g]),
      .r0_b     (bus.r0_b[g]),
      .r1_a     (bus.r1_a[g]),
      .r1_b     (bus.r1_b[g]),
      .result   (bus.dsp_result[g]),
      .dsp_a    (a_q[g]),
      .dsp_b    (b_q[g]),
      .rsp_data (d_q[g])
    );
  end

  assign bus.dsp_a        = a_q;
  assign bus.dsp_b        = b_q;
  assign bus.rsp_data     = d_q;
  assign bus.dsp_op       = op_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.last_grant   = last_q;
  assign bus.dsp_start    = (state == ISSUE);
  assign bus.dsp_rst      = (state == FLUSH);
  assign bus.busy         = (state != IDLE);
  assign bus.r0_gnt       = (state == ISSUE) & ~owner;
  assign bus.r1_gnt       = (state == ISSUE) &  owner;
  assign bus.r0_rsp_valid = (state == RESP)  & ~owner;
  assign bus.r1_rsp_valid = (state == RESP)  &  owner;
endmodule

// File: tb/tb_dsp_arbiter.sv
// Bench for dsp_arbiter: behavioural DSP stub plus directed and randomized scenarios.
module tb_dsp_arbiter;
  localparam int NL  = 8;
  localparam int VW  = 32;
  localparam int TMO = 16;
  localparam int FLC = 2;
  typedef logic [NL-1:0][VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   stub_hang = 1'b0;
  int   stub_lat_fix = 0;
  bit   st_pend;
  int   st_cnt, st_hold;

  dsp_arbiter_if #(.NUM_LANES(NL), .VEC_W(VW)) bus ();

  dsp_arbiter #(.TIMEOUT(TMO), .FLUSH_CYC(FLC), .NUM_LANES(NL), .VEC_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // DSP vector unit reference behaviour
  function automatic vec_t golden(input logic [1:0] op, input vec_t a, input vec_t b);
    vec_t y;
    for (int n = 0; n < NL; n++) begin
      case (op)
        2'b00: y[n] = a[n] + b[n];
        2'b01: y[n] = a[n] * b[n];
        2'b11: y[n] = a[n] - b[n];
        default: begin
          y[n] = '0;
          for (int k = 0; k <= n; k++) y[n] = y[n] + a[k] * b[n-k];
        end
      endcase
    end
    return y;
  endfunction

  // DSP stub: latches operands on start, raises done after a latency, holds it a few cycles
  always @(posedge clk) begin
    if (rst || bus.dsp_rst) begin
      st_pend      <= 1'b0;
      bus.dsp_done <= 1'b0;
    end else if (bus.dsp_start) begin
      bus.dsp_result <= golden(bus.dsp_op, bus.dsp_a, bus.dsp_b);
      st_pend        <= 1'b1;
      st_cnt         <= (stub_lat_fix != 0) ? stub_lat_fix : int'($urandom_range(8, 1));
      st_hold        <= int'($urandom_range(3, 1));
      bus.dsp_done   <= 1'b0;
    end else if (st_pend) begin
      if (!stub_hang) begin
        if (st_cnt <= 1) begin
          st_pend      <= 1'b0;
          bus.dsp_done <= 1'b1;
        end else st_cnt <= st_cnt - 1;
      end
    end else if (bus.dsp_done) begin
      if (st_hold <= 1) bus.dsp_done <= 1'b0;
      else              st_hold <= st_hold - 1;
    end
  end

  task automatic clear_inputs();
    bus.r0_req = 0; bus.r0_op = 0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_rsp_ready = 0;
    bus.r1_req = 0; bus.r1_op = 0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_rsp_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_req(input int id, input logic [1:0] op, input vec_t a, input vec_t b);
    if (id == 0) begin bus.r0_op = op; bus.r0_a = a; bus.r0_b = b; bus.r0_req = 1'b1; end
    else         begin bus.r1_op = op; bus.r1_a = a; bus.r1_b = b; bus.r1_req = 1'b1; end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) bus.r0_req = 1'b0;
    else         bus.r1_req = 1'b0;
  endtask

  task automatic finish_rsp(input int id);
    if (id == 0) bus.r0_rsp_ready = 1'b1; else bus.r1_rsp_ready = 1'b1;
    @(negedge clk);
    bus.r0_rsp_ready = 1'b0;
    bus.r1_rsp_ready = 1'b0;
  endtask

  task automatic wait_gnt(input int id, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if ((id == 0 ? bus.r0_gnt : bus.r1_gnt) === 1'b1) begin cyc = c; break; end
    end
  endtask

  task automatic wait_any_gnt(output int who);
    who = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.r0_gnt === 1'b1) begin who = 0; break; end
      if (bus.r1_gnt === 1'b1) begin who = 1; break; end
    end
  endtask

  // waits for the owner's response; flags any change of the DSP operands meanwhile
  task automatic wait_valid(input int id, input logic [1:0] op, input vec_t a, input vec_t b,
                            output int cyc, output bit uns);
    cyc = -1;
    uns = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.dsp_op !== op || bus.dsp_a !== a || bus.dsp_b !== b) uns = 1'b1;
      if ((id == 0 ? bus.r0_rsp_valid : bus.r1_rsp_valid) === 1'b1) begin cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rsp_valid, bus.r1_rsp_valid, bus.rsp_err, bus.dsp_start,
         bus.dsp_rst, bus.busy, bus.last_grant} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.r0_gnt, bus.r1_gnt, bus.r0_rsp_valid,
        bus.r1_rsp_valid, bus.rsp_err, bus.dsp_start, bus.dsp_rst, bus.busy, bus.last_grant});
    end
    checks++;
    if (bus.dsp_op !== 2'b00) begin failures++; $display("FAIL reset_op got=%b exp=00", bus.dsp_op); end
    checks++;
    if (bus.dsp_a !== '0 || bus.dsp_b !== '0) begin
      failures++; $display("FAIL reset_operands got_a=%h got_b=%h exp=0", bus.dsp_a, bus.dsp_b);
    end
    checks++;
    if (bus.rsp_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.rsp_data); end
  endtask

  task automatic test_single_add();
    vec_t a, b, exp;
    int   cg, cv;
    bit   uns;
    for (int i = 0; i < NL; i++) begin a[i] = i; b[i] = 10; exp[i] = i + 10; end
    do_reset();
    drive_req(0, 2'b00, a, b);
    wait_gnt(0, cg);
    drop_req(0);
    checks++;
    if (cg != 1) begin failures++; $display("FAIL add_gnt_latency got=%0d exp=1", cg); end
    checks++;
    if (bus.dsp_start !== 1'b1) begin failures++; $display("FAIL add_start_with_gnt got=%b exp=1", bus.dsp_start); end
    @(negedge clk);
    checks++;
    if ({bus.r0_gnt, bus.dsp_start} !== 2'b00) begin
      failures++; $display("FAIL add_pulse_width got=%b exp=00", {bus.r0_gnt, bus.dsp_start});
    end
    wait_valid(0, 2'b00, a, b, cv, uns);
    checks++;
    if (cv < 0 || uns) begin failures++; $display("FAIL add_valid got_cyc=%0d unstable=%b exp=done,0", cv, uns); end
    checks++;
    if (bus.rsp_data !== exp || bus.rsp_err !== 1'b0) begin
      failures++; $display("FAIL add_data got=%h err=%b exp=%h err=0", bus.rsp_data, bus.rsp_err, exp);
    end
    checks++;
    if ({bus.r1_gnt, bus.r1_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL add_r1_quiet got=%b exp=00", {bus.r1_gnt, bus.r1_rsp_valid});
    end
    finish_rsp(0);
    checks++;
    if ({bus.r0_rsp_valid, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL add_release got=%b exp=00", {bus.r0_rsp_valid, bus.busy});
    end
  endtask

  task automatic test_contention();
    vec_t       ca[2], cb[2], ce[2];
    logic [1:0] cop[2];
    int         who, cv;
    bit         uns;
    cop[0] = 2'b01; cop[1] = 2'b11;
    for (int i = 0; i < NL; i++) begin
      ca[0][i] = 3;   cb[0][i] = i; ce[0][i] = 3 * i;
      ca[1][i] = 100; cb[1][i] = i; ce[1][i] = 100 - i;
    end
    do_reset();
    drive_req(0, cop[0], ca[0], cb[0]);
    drive_req(1, cop[1], ca[1], cb[1]);
    // both held throughout: grants must alternate starting with r0
    for (int g = 0; g < 4; g++) begin
      wait_any_gnt(who);
      checks++;
      if (who != g % 2) begin failures++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", g, who, g % 2); end
      if (who < 0) break;
      checks++;
      if (bus.last_grant !== 1'(g % 2)) begin
        failures++; $display("FAIL contention_last_grant[%0d] got=%b exp=%0d", g, bus.last_grant, g % 2);
      end
      wait_valid(who, cop[who], ca[who], cb[who], cv, uns);
      checks++;
      if (cv < 0 || uns || bus.rsp_data !== ce[who]) begin
        failures++; $display("FAIL contention_data[%0d] got=%h exp=%h", g, bus.rsp_data, ce[who]);
      end
      finish_rsp(who);
    end
    drop_req(0);
    drop_req(1);
  endtask

  task automatic test_fir();
    vec_t a, b, exp;
    int   cg, cv;
    bit   uns;
    for (int i = 0; i < NL; i++) begin a[i] = (i == 0) ? 1 : 0; b[i] = i + 1; exp[i] = i + 1; end
    drive_req(1, 2'b10, a, b);
    wait_gnt(1, cg);
    drop_req(1);
    checks++;
    if (cg < 0 || bus.last_grant !== 1'b1) begin
      failures++; $display("FAIL fir_gnt got_cyc=%0d last=%b exp=granted,1", cg, bus.last_grant);
    end
    wait_valid(1, 2'b10, a, b, cv, uns);
    checks++;
    if (uns) begin failures++; $display("FAIL fir_operand_hold got=unstable exp=stable"); end
    checks++;
    if (cv < 0 || bus.rsp_data !== exp || bus.rsp_err !== 1'b0) begin
      failures++; $display("FAIL fir_data got=%h err=%b exp=%h err=0", bus.rsp_data, bus.rsp_err, exp);
    end
    checks++;
    if (bus.r0_rsp_valid !== 1'b0) begin failures++; $display("FAIL fir_r0_quiet got=%b exp=0", bus.r0_rsp_valid); end
    finish_rsp(1);
  endtask

  task automatic test_backpressure();
    vec_t a, b, a1, b1, d0;
    int   cg, cv;
    bit   uns, bad;
    for (int i = 0; i < NL; i++) begin
      a[i] = $urandom(); b[i] = $urandom(); a1[i] = $urandom(); b1[i] = $urandom();
    end
    drive_req(0, 2'b00, a, b);
    wait_gnt(0, cg);
    drop_req(0);
    wait_valid(0, 2'b00, a, b, cv, uns);
    d0 = bus.rsp_data;
    checks++;
    if (cv < 0 || d0 !== golden(2'b00, a, b)) begin
      failures++; $display("FAIL bp_data got=%h exp=%h", d0, golden(2'b00, a, b));
    end
    drive_req(1, 2'b00, a1, b1);
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.r0_rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.busy !== 1'b1 || bus.r1_gnt !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL bp_hold got=changed exp=valid,data,busy stable and no r1 gnt"); end
    finish_rsp(0);
    checks++;
    if ({bus.r0_rsp_valid, bus.r1_gnt} !== 2'b00) begin
      failures++; $display("FAIL bp_idle_gap got=%b exp=00", {bus.r0_rsp_valid, bus.r1_gnt});
    end
    @(negedge clk);
    checks++;
    if (bus.r1_gnt !== 1'b1) begin failures++; $display("FAIL bp_r1_gnt got=%b exp=1", bus.r1_gnt); end
    drop_req(1);
    wait_valid(1, 2'b00, a1, b1, cv, uns);
    checks++;
    if (cv < 0 || bus.rsp_data !== golden(2'b00, a1, b1)) begin
      failures++; $display("FAIL bp_r1_data got=%h exp=%h", bus.rsp_data, golden(2'b00, a1, b1));
    end
    finish_rsp(1);
  endtask

  task automatic test_timeout();
    vec_t a, b;
    int   cg, cv, nwait, nflush;
    bit   gap, uns;
    for (int i = 0; i < NL; i++) begin a[i] = $urandom_range(1000, 0); b[i] = $urandom_range(1000, 0); end
    stub_hang = 1'b1;
    drive_req(0, 2'b00, a, b);
    wait_gnt(0, cg);
    drop_req(0);
    nwait = 0; nflush = 0; cv = -1; gap = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.r0_rsp_valid === 1'b1) begin cv = c; break; end
      if (bus.dsp_rst === 1'b1) nflush++;
      else if (nflush > 0) gap = 1'b1;
      else if (bus.busy === 1'b1) nwait++;
    end
    checks++;
    if (nwait != TMO) begin failures++; $display("FAIL timeout_wait_cycles got=%0d exp=%0d", nwait, TMO); end
    checks++;
    if (nflush != FLC || gap) begin failures++; $display("FAIL timeout_flush got=%0d gap=%b exp=%0d gap=0", nflush, gap, FLC); end
    checks++;
    if (cv < 0 || bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin
      failures++; $display("FAIL timeout_rsp got_err=%b data=%h exp_err=1 data=0", bus.rsp_err, bus.rsp_data);
    end
    finish_rsp(0);
    stub_hang = 1'b0;
    for (int i = 0; i < NL; i++) begin a[i] = $urandom(); b[i] = $urandom(); end
    drive_req(0, 2'b00, a, b);
    wait_gnt(0, cg);
    drop_req(0);
    wait_valid(0, 2'b00, a, b, cv, uns);
    checks++;
    if (cv < 0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== golden(2'b00, a, b)) begin
      failures++; $display("FAIL timeout_recover got=%h err=%b exp=%h err=0", bus.rsp_data, bus.rsp_err, golden(2'b00, a, b));
    end
    finish_rsp(0);
  endtask

  task automatic test_reset_mid();
    vec_t a, b;
    int   cg, cv;
    bit   uns;
    for (int i = 0; i < NL; i++) begin a[i] = $urandom_range(9, 0); b[i] = $urandom_range(9, 0); end
    stub_lat_fix = 12;
    drive_req(1, 2'b10, a, b);
    wait_gnt(1, cg);
    drop_req(1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.dsp_rst, bus.dsp_start, bus.r1_rsp_valid, bus.r1_gnt, bus.rsp_err, bus.last_grant} !== 7'd0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b exp=0", {bus.busy, bus.dsp_rst, bus.dsp_start,
        bus.r1_rsp_valid, bus.r1_gnt, bus.rsp_err, bus.last_grant});
    end
    checks++;
    if (bus.dsp_a !== '0 || bus.dsp_b !== '0 || bus.dsp_op !== 2'b00 || bus.rsp_data !== '0) begin
      failures++; $display("FAIL rstmid_data got_a=%h got_data=%h exp=0", bus.dsp_a, bus.rsp_data);
    end
    rst = 1'b0;
    stub_lat_fix = 0;
    for (int i = 0; i < NL; i++) begin a[i] = $urandom(); b[i] = $urandom(); end
    drive_req(0, 2'b10, a, b);
    wait_gnt(0, cg);
    drop_req(0);
    wait_valid(0, 2'b10, a, b, cv, uns);
    checks++;
    if (cv < 0 || uns || bus.rsp_err !== 1'b0 || bus.rsp_data !== golden(2'b10, a, b)) begin
      failures++; $display("FAIL rstmid_after got=%h err=%b exp=%h err=0", bus.rsp_data, bus.rsp_err, golden(2'b10, a, b));
    end
    finish_rsp(0);
  endtask

  // random ops from one or both requesters; winner model: alternate away from the last grant
  task automatic test_random();
    vec_t       ra[2], rb[2], d;
    logic [1:0] rop[2];
    bit         pend[2];
    int         mdl_last, who, exp_who, cv, dly, pick;
    bit         uns, hold_bad;
    do_reset();
    mdl_last = -1;
    for (int t = 0; t < 24; t++) begin
      pick = $urandom_range(2, 0);
      for (int r = 0; r < 2; r++) begin
        pend[r] = (pick == 2) || (pick == r);
        rop[r]  = 2'($urandom_range(3, 0));
        for (int i = 0; i < NL; i++) begin ra[r][i] = $urandom(); rb[r][i] = $urandom(); end
        if (pend[r]) drive_req(r, rop[r], ra[r], rb[r]);
      end
      while (pend[0] || pend[1]) begin
        exp_who = (pend[0] && pend[1]) ? ((mdl_last == 0) ? 1 : 0) : (pend[0] ? 0 : 1);
        wait_any_gnt(who);
        checks++;
        if (who != exp_who) begin failures++; $display("FAIL rand_winner[%0d] got=%0d exp=%0d", t, who, exp_who); end
        if (who < 0) begin
          drop_req(0); drop_req(1); pend[0] = 0; pend[1] = 0;
        end else begin
          drop_req(who);
          pend[who] = 0;
          mdl_last  = who;
          checks++;
          if (bus.last_grant !== 1'(who)) begin
            failures++; $display("FAIL rand_last_grant[%0d] got=%b exp=%0d", t, bus.last_grant, who);
          end
          wait_valid(who, rop[who], ra[who], rb[who], cv, uns);
          d = golden(rop[who], ra[who], rb[who]);
          checks++;
          if (cv < 0 || uns || bus.rsp_err !== 1'b0 || bus.rsp_data !== d) begin
            failures++; $display("FAIL rand_data[%0d] op=%b got=%h exp=%h", t, rop[who], bus.rsp_data, d);
          end
          dly = $urandom_range(3, 0);
          hold_bad = 1'b0;
          for (int c = 0; c < dly; c++) begin
            @(negedge clk);
            if ((who == 0 ? bus.r0_rsp_valid : bus.r1_rsp_valid) !== 1'b1 || bus.rsp_data !== d) hold_bad = 1'b1;
          end
          checks++;
          if (hold_bad) begin failures++; $display("FAIL rand_rsp_hold[%0d] got=changed exp=stable", t); end
          finish_rsp(who);
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_add();
    test_contention();
    test_fir();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation watchdog expired");
  end
endmodule
